// File: rtl/ft2232h_sync_fifo_model_pkg.sv
// Shared constants and types for the FT2232H 245 synchronous-FIFO bench model.
package ft2232h_sync_fifo_model_pkg;

  localparam int unsigned DATA_BUS   = 8;
  localparam int unsigned FIFO_DEPTH = 16;

  // Bit positions inside proto_err
  localparam int unsigned ERR_RD    = 0;
  localparam int unsigned ERR_WR    = 1;
  localparam int unsigned ERR_OE_WR = 2;

  localparam int unsigned FT_PKT_BYTES = 512;
  localparam int unsigned FT_RX_GAP    = 8;
  localparam int unsigned FT_TX_GAP    = 4;
  localparam int unsigned PKT_W        = $clog2(FT_PKT_BYTES);

  typedef enum logic [1:0] {
    StIdle,
    StTurn,
    StDrive
  } bus_state_e;

endpackage

// File: rtl/ft2232h_sync_fifo_model_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a pop frees room for a same-cycle push when full.
module ft2232h_sync_fifo_model_sync_fifo #(
  parameter int unsigned DATA  = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ADDR  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr,
  input  logic            rd,
  input  logic [DATA-1:0] din,
  output logic [DATA-1:0] dout,
  output logic            full,
  output logic            empty,
  output logic [ADDR:0]   count,
  output logic [ADDR:0]   count_nxt
);

  localparam logic [ADDR:0] CntFull = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] CntOne  = (ADDR+1)'(1);

  logic [DATA-1:0] mem_q [DEPTH];
  logic [ADDR-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR:0]   count_q;
  logic            wr_ok, rd_ok;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);
  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd_ok);
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    count_nxt = count_q;
    if (wr_ok && !rd_ok) begin
      count_nxt = count_q + CntOne;
    end else if (!wr_ok && rd_ok) begin
      count_nxt = count_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + ADDR'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + ADDR'(1);
      count_q <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ft2232h_sync_fifo_model.sv
// FT2232H 245 sync-FIFO bench model: RX/TX FIFOs, OE#-turnaround bus FSM, sticky protocol flags.
// Define FT_USB_PACKET_EN to add 512-byte packet gaps on RXF#/TXE#.
module ft2232h_sync_fifo_model
  import ft2232h_sync_fifo_model_pkg::*;
#(
  parameter int unsigned DATA     = DATA_BUS,
  parameter int unsigned RX_DEPTH = FIFO_DEPTH,
  parameter int unsigned TX_DEPTH = FIFO_DEPTH,
  parameter int unsigned RX_ADDR  = $clog2(RX_DEPTH),
  parameter int unsigned TX_ADDR  = $clog2(TX_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             H_wr,
  input  logic [DATA-1:0]  H_din,
  output logic             H_rx_full,
  input  logic             H_rd,
  output logic [DATA-1:0]  H_dout,
  output logic             H_dout_vld,
  output logic [TX_ADDR:0] H_tx_count,
  output logic             H_flush,
  output logic [2:0]       proto_err,
  inout  wire  [DATA-1:0]  DBUS,
  output logic             RXF_n,
  output logic             TXE_n,
  input  logic             RD_n,
  input  logic             WR_n,
  input  logic             OE_n,
  input  logic             SIWU_n
);

  localparam logic [TX_ADDR:0] TxFull = (TX_ADDR+1)'(TX_DEPTH);

  bus_state_e state_q, state_d;

  logic [DATA-1:0]  rx_head, tx_head;
  logic             rx_full, rx_empty, tx_full, tx_empty;
  logic [RX_ADDR:0] rx_count, rx_count_nxt;
  logic [TX_ADDR:0] tx_count, tx_count_nxt;

  logic             rxf_n_q, rxf_n_d, txe_n_q, txe_n_d;
  logic [DATA-1:0]  dout_q;
  logic             vld_q, vld_d, flush_q, flush_d, siwu_q;
  logic [2:0]       proto_err_q, proto_err_d;

  logic drive_bus, rx_pop, tx_push, rd_bad, wr_bad, oe_wr_bad;
  logic unused_fifo_status;

  assign drive_bus = (state_q == StDrive) && !OE_n;
  assign rx_pop    = drive_bus && !RD_n && !rxf_n_q;
  assign tx_push   = !WR_n && !txe_n_q && OE_n;
  assign rd_bad    = !RD_n && !rx_pop;
  assign wr_bad    = !WR_n && txe_n_q;
  assign oe_wr_bad = !WR_n && !OE_n;

  // Released combinationally the moment OE_n rises.
  assign DBUS = drive_bus ? rx_head : {DATA{1'bz}};

  assign unused_fifo_status = ^{rx_empty, rx_count, tx_full};

  ft2232h_sync_fifo_model_sync_fifo #(
    .DATA  (DATA),
    .DEPTH (RX_DEPTH),
    .ADDR  (RX_ADDR)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr        (H_wr),
    .rd        (rx_pop),
    .din       (H_din),
    .dout      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count),
    .count_nxt (rx_count_nxt)
  );

  ft2232h_sync_fifo_model_sync_fifo #(
    .DATA  (DATA),
    .DEPTH (TX_DEPTH),
    .ADDR  (TX_ADDR)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr        (tx_push),
    .rd        (H_rd),
    .din       (DBUS),
    .dout      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count),
    .count_nxt (tx_count_nxt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (!OE_n) state_d = StTurn;
      StTurn:  state_d = OE_n ? StIdle : StDrive;
      StDrive: if (OE_n) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef FT_USB_PACKET_EN
  logic [PKT_W-1:0] rx_pkt_q, tx_pkt_q;
  logic [3:0]       rx_gap_q, rx_gap_d;
  logic [2:0]       tx_gap_q, tx_gap_d;
  logic             rx_pkt_end, tx_pkt_end;

  assign rx_pkt_end = rx_pop && (rx_pkt_q == PKT_W'(FT_PKT_BYTES - 1));
  assign tx_pkt_end = tx_push && (tx_pkt_q == PKT_W'(FT_PKT_BYTES - 1));

  always_comb begin
    rx_gap_d = '0;
    // An emptied FIFO abandons the gap; RXF_n is high then anyway.
    if (rx_count_nxt == '0)    rx_gap_d = '0;
    else if (rx_pkt_end)       rx_gap_d = 4'(FT_RX_GAP);
    else if (rx_gap_q != '0)   rx_gap_d = rx_gap_q - 4'd1;
    tx_gap_d = '0;
    if (tx_pkt_end)            tx_gap_d = 3'(FT_TX_GAP);
    else if (tx_gap_q != '0)   tx_gap_d = tx_gap_q - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_pkt_q <= '0;
      tx_pkt_q <= '0;
      rx_gap_q <= '0;
      tx_gap_q <= '0;
    end else begin
      if (rx_pop)  rx_pkt_q <= rx_pkt_q + PKT_W'(1);
      if (tx_push) tx_pkt_q <= tx_pkt_q + PKT_W'(1);
      rx_gap_q <= rx_gap_d;
      tx_gap_q <= tx_gap_d;
    end
  end
`endif

  always_comb begin
    proto_err_d = proto_err_q;
    if (rd_bad)    proto_err_d[ERR_RD]    = 1'b1;
    if (wr_bad)    proto_err_d[ERR_WR]    = 1'b1;
    if (oe_wr_bad) proto_err_d[ERR_OE_WR] = 1'b1;
    flush_d = siwu_q && !SIWU_n;
    vld_d   = H_rd && !tx_empty;
`ifdef FT_USB_PACKET_EN
    rxf_n_d = (rx_count_nxt == '0) || (rx_gap_d != '0);
    txe_n_d = (tx_count_nxt == TxFull) || (tx_gap_d != '0);
`else
    rxf_n_d = (rx_count_nxt == '0);
    txe_n_d = (tx_count_nxt == TxFull);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rxf_n_q     <= 1'b1;
      txe_n_q     <= 1'b1;
      dout_q      <= '0;
      vld_q       <= 1'b0;
      flush_q     <= 1'b0;
      siwu_q      <= 1'b1;
      proto_err_q <= '0;
    end else begin
      state_q     <= state_d;
      rxf_n_q     <= rxf_n_d;
      txe_n_q     <= txe_n_d;
      if (vld_d) dout_q <= tx_head;
      vld_q       <= vld_d;
      flush_q     <= flush_d;
      siwu_q      <= SIWU_n;
      proto_err_q <= proto_err_d;
    end
  end

  assign RXF_n      = rxf_n_q;
  assign TXE_n      = txe_n_q;
  assign H_dout     = dout_q;
  assign H_dout_vld = vld_q;
  assign H_flush    = flush_q;
  assign proto_err  = proto_err_q;
  assign H_tx_count = tx_count;
  // A same-edge pop frees a slot, so the host may write into a full FIFO then.
  assign H_rx_full  = rx_full && !rx_pop;

endmodule
